// File: rtl/ks_pkg.sv
// Shared types and helpers for the ksneq32 key loader: FSM states, core width codes,
// error codes and word-count arithmetic.
package ks_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_KS_START  = 3'd2,
    ST_KS_WAIT   = 3'd3,
    ST_OUT_VALID = 3'd4,
    ST_ERROR     = 3'd5
  } ksState_t;

  typedef enum logic [1:0] {
    KW_MIN  = 2'd0,
    KW_FAST = 2'd1,
    KW_FULL = 2'd2
  } kwidth_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic int wordsOf(input int bits);
    return bits / 32;
  endfunction

  // Counter must hold KWORDS_MAX+1 so an over-long key with s_last still decodes as illegal.
  function automatic int cntWidth(input int maxWords);
    return $clog2(maxWords + 2);
  endfunction

endpackage

// File: rtl/ks_word_asm.sv
// Key word assembler: word counter, placement of 32-bit words into the key register,
// and decode of the final word count into a core width code or an error.
module ks_word_asm
  import ks_pkg::*;
#(
  parameter int MINWIDTH_K = 128,
  parameter int KWIDTHMAX  = 448,
  parameter int CWIDTH     = 320,
  parameter int XWIDTH     = 128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 accept,
  input  logic                 first,
  input  logic                 last,
  input  logic                 clrCnt,
  input  logic [31:0]          word,
  output logic [KWIDTHMAX-1:0] k,
  output kwidth_t              kwSel,
  output logic                 lenOk,
  output logic                 overflow
);

  localparam int KWORDS_MAX = wordsOf(KWIDTHMAX);
  localparam int CNT_W      = cntWidth(KWORDS_MAX);

  localparam logic [CNT_W-1:0] N_MIN  = CNT_W'(wordsOf(MINWIDTH_K));
  localparam logic [CNT_W-1:0] N_FAST = CNT_W'(wordsOf(MINWIDTH_K + XWIDTH));
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(wordsOf(CWIDTH + XWIDTH));
  localparam logic [CNT_W-1:0] N_MAX  = CNT_W'(KWORDS_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nNext;

  // Count including the word being accepted this cycle.
  assign nNext = first ? CNT_W'(1) : cnt + CNT_W'(1);

  always_comb begin
    lenOk = 1'b0;
    kwSel = KW_MIN;
    if (nNext == N_MIN) begin
      lenOk = 1'b1;
      kwSel = KW_MIN;
    end else if (nNext == N_FAST) begin
      lenOk = 1'b1;
      kwSel = KW_FAST;
    end else if (nNext == N_FULL) begin
      lenOk = 1'b1;
      kwSel = KW_FULL;
    end
  end

  assign overflow = accept && !first && !last && (cnt == N_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k   <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (first) begin
        k   <= {{(KWIDTHMAX-32){1'b0}}, word};
        cnt <= CNT_W'(1);
      end else if (cnt < N_MAX) begin
        for (int i = 1; i < KWORDS_MAX; i++) begin
          if (cnt == CNT_W'(i)) k[i*32 +: 32] <= word;
        end
        cnt <= cnt + CNT_W'(1);
      end
    end else if (clrCnt) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/ks_key_loader.sv
// Streams a key into the ksneq32 core, pulses en, waits for done and returns C/X state.
// Optional done watchdog enabled by defining KS_LOADER_TIMEOUT_EN.
module ks_key_loader
  import ks_pkg::*;
#(
  parameter int MINWIDTH_K     = 128,
  parameter int KWIDTHMAX      = 448,
  parameter int CWIDTH         = 320,
  parameter int XWIDTH         = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          s_word,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [KWIDTHMAX-1:0] ks_k,
  output logic [1:0]           ks_kwidth,
  output logic                 ks_en,
  output logic                 ks_reset,
  input  logic                 ks_done,
  input  logic [CWIDTH-1:0]    ks_cout,
  input  logic [XWIDTH-1:0]    ks_xout,
  output logic [CWIDTH-1:0]    m_c,
  output logic [XWIDTH-1:0]    m_x,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 err,
  output logic [1:0]           err_code,
  input  logic                 err_clr
);

  localparam int N_MIN      = wordsOf(MINWIDTH_K);
  localparam int N_FAST     = wordsOf(MINWIDTH_K + XWIDTH);
  localparam int N_FULL     = wordsOf(CWIDTH + XWIDTH);
  localparam int KWORDS_MAX = wordsOf(KWIDTHMAX);

  generate
    if (N_MIN == N_FAST || N_MIN == N_FULL || N_FAST == N_FULL ||
        N_MIN > KWORDS_MAX || N_FAST > KWORDS_MAX || N_FULL > KWORDS_MAX ||
        KWORDS_MAX < 1 || TIMEOUT_CYCLES < 1) begin : gBadCfg
      $error("ks_key_loader: key word counts must be distinct and fit in KWIDTHMAX");
    end
  endgenerate

  ksState_t state;
  kwidth_t  kwidthQ;
  kwidth_t  kwSel;
  logic     readyEn;
  logic     accept;
  logic     wordFirst;
  logic     clrCnt;
  logic     lenOk;
  logic     overflow;

  // readyEn keeps the stream closed for the first cycle after reset release.
  assign s_ready   = readyEn && (state == ST_IDLE || state == ST_LOAD);
  assign accept    = s_valid && s_ready;
  assign wordFirst = (state == ST_IDLE);
  assign clrCnt    = (state == ST_ERROR) && err_clr;
  assign ks_kwidth = kwidthQ;

  ks_word_asm #(
    .MINWIDTH_K(MINWIDTH_K),
    .KWIDTHMAX (KWIDTHMAX),
    .CWIDTH    (CWIDTH),
    .XWIDTH    (XWIDTH)
  ) uWordAsm (
    .clk     (clk),
    .reset_n (reset_n),
    .accept  (accept),
    .first   (wordFirst),
    .last    (s_last),
    .clrCnt  (clrCnt),
    .word    (s_word),
    .k       (ks_k),
    .kwSel   (kwSel),
    .lenOk   (lenOk),
    .overflow(overflow)
  );

`ifdef KS_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] toCnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      readyEn  <= 1'b0;
      ks_reset <= 1'b1;
      ks_en    <= 1'b0;
      m_valid  <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      kwidthQ  <= KW_MIN;
      m_c      <= '0;
      m_x      <= '0;
`ifdef KS_LOADER_TIMEOUT_EN
      toCnt    <= '0;
`endif
    end else begin
      readyEn <= 1'b1;
      ks_en   <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          // Length check takes priority over overflow when s_last arrives.
          if (accept) begin
            if (s_last) begin
              if (lenOk) begin
                state    <= ST_KS_START;
                kwidthQ  <= kwSel;
                ks_en    <= 1'b1;
                ks_reset <= 1'b0;
              end else begin
                state    <= ST_ERROR;
                err      <= 1'b1;
                err_code <= ERR_BAD_LEN;
              end
            end else if (overflow) begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_KS_START: begin
          state <= ST_KS_WAIT;
`ifdef KS_LOADER_TIMEOUT_EN
          toCnt <= '0;
`endif
        end
        ST_KS_WAIT: begin
          if (ks_done) begin
            m_c     <= ks_cout;
            m_x     <= ks_xout;
            m_valid <= 1'b1;
            state   <= ST_OUT_VALID;
          end
`ifdef KS_LOADER_TIMEOUT_EN
          else if (toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state    <= ST_ERROR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            ks_reset <= 1'b1;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
`endif
        end
        ST_OUT_VALID: begin
          if (m_ready) begin
            m_valid  <= 1'b0;
            ks_reset <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (err_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ks_reset <= 1'b1;
          m_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ks_key_loader.sv
// Directed bench for ks_key_loader with a behavioural ksneq32 stand-in that raises done
// 20 cycles after en; watchdog checks follow KS_LOADER_TIMEOUT_EN.
module tb_ks_key_loader;

  localparam int KW = 448;
  localparam int CW = 320;
  localparam int XW = 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   s_word = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [KW-1:0] ks_k;
  logic [1:0]    ks_kwidth;
  logic          ks_en;
  logic          ks_reset;
  logic          ks_done;
  logic [CW-1:0] ks_cout;
  logic [XW-1:0] ks_xout;
  logic [CW-1:0] m_c;
  logic [XW-1:0] m_x;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          err;
  logic [1:0]    err_code;
  logic          err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int enCount = 0;
  int coreCnt = 0;
  logic coreRun = 1'b0;
  logic doneEnable = 1'b1;
  logic [31:0] coutPat = 32'h0;

  always #5 clk = ~clk;

  assign ks_cout = {10{coutPat}};
  assign ks_xout = {4{~coutPat}};

  ks_key_loader #(
    .MINWIDTH_K(128), .KWIDTHMAX(KW), .CWIDTH(CW), .XWIDTH(XW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_word(s_word), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .ks_k(ks_k), .ks_kwidth(ks_kwidth), .ks_en(ks_en),
    .ks_reset(ks_reset), .ks_done(ks_done), .ks_cout(ks_cout), .ks_xout(ks_xout),
    .m_c(m_c), .m_x(m_x), .m_valid(m_valid), .m_ready(m_ready), .err(err),
    .err_code(err_code), .err_clr(err_clr)
  );

  // Core stand-in: done rises 20 cycles after the en pulse and holds until reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coreRun <= 1'b0; coreCnt <= 0; ks_done <= 1'b0;
    end else if (ks_reset) begin
      coreRun <= 1'b0; coreCnt <= 0; ks_done <= 1'b0;
    end else if (ks_en) begin
      coreRun <= 1'b1; coreCnt <= 0; ks_done <= 1'b0;
    end else if (coreRun && doneEnable) begin
      if (coreCnt == 19) ks_done <= 1'b1;
      coreCnt <= coreCnt + 1;
    end
  end

  always @(posedge clk) if (ks_en) enCount <= enCount + 1;

  task automatic checkEq(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkWord(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction

  function automatic logic [KW-1:0] expKey(input int n, input int base);
    logic [KW-1:0] k = '0;
    for (int i = 0; i < n; i++) k[i*32 +: 32] = mkWord(base + i);
    return k;
  endfunction

  // Returns one time unit after the edge that accepted the final word.
  task automatic sendWords(input int n, input logic lastOnFinal, input int base);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_word  = mkWord(base + i);
      s_last  = lastOnFinal && (i == n - 1);
      guard = 0;
      while (!s_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard == 50) begin
        checkEq("s_ready_wait", 0, 1);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic runKey(input int n, input int base, input logic [1:0] kwExp, input logic [31:0] pat);
    int e0;
    int cycles;
    coutPat = pat;
    e0 = enCount;
    sendWords(n, 1'b1, base);
    checkEq("en_high", ks_en, 1);
    checkEq("ks_reset_low", ks_reset, 0);
    @(posedge clk); #1;
    checkEq("en_one_pulse", ks_en, 0);
    cycles = 1;
    while (!m_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkEq("done_latency", cycles, 22);
    checkEq("kwidth", ks_kwidth, kwExp);
    checkEq("ks_k", ks_k, expKey(n, base));
    checkEq("m_c", m_c, {10{pat}});
    checkEq("m_x", m_x, {4{~pat}});
    checkEq("en_count", enCount - e0, 1);
    repeat (3) begin @(posedge clk); #1; end
    checkEq("m_valid_hold", m_valid, 1);
    checkEq("ks_k_hold", ks_k, expKey(n, base));
    checkEq("s_ready_busy", s_ready, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checkEq("m_valid_drop", m_valid, 0);
    checkEq("s_ready_back", s_ready, 1);
    checkEq("ks_reset_back", ks_reset, 1);
  endtask

  initial begin
    #13;
    checkEq("rst_s_ready", s_ready, 0);
    checkEq("rst_ks_reset", ks_reset, 1);
    checkEq("rst_ks_en", ks_en, 0);
    checkEq("rst_m_valid", m_valid, 0);
    checkEq("rst_err", err, 0);
    checkEq("rst_err_code", err_code, 0);
    checkEq("rst_ks_k", ks_k, 0);
    checkEq("rst_kwidth", ks_kwidth, 0);
    checkEq("rst_m_c", m_c, 0);
    checkEq("rst_m_x", m_x, 0);
    reset_n = 1'b1;
    #1;
    checkEq("s_ready_gated", s_ready, 0);
    @(posedge clk); #1;
    checkEq("s_ready_rise", s_ready, 1);

    // MIN key, plus literal check of the assembled 128-bit value
    runKey(4, 0, 2'd0, 32'hC0DE_0001);
    checkEq("ks_k_literal", ks_k, {320'h0, 128'h0F0E0D0C_0B0A0908_07060504_03020100});
    runKey(8, 16, 2'd1, 32'hC0DE_0002);
    runKey(14, 40, 2'd2, 32'hC0DE_0003);

    // Illegal length, recovery, then a good key
    sendWords(5, 1'b1, 0);
    checkEq("badlen_err", err, 1);
    checkEq("badlen_code", err_code, 1);
    checkEq("badlen_s_ready", s_ready, 0);
    checkEq("badlen_ks_reset", ks_reset, 1);
    pulseErrClr();
    checkEq("clr_err", err, 0);
    checkEq("clr_code", err_code, 0);
    checkEq("clr_s_ready", s_ready, 1);
    runKey(4, 3, 2'd0, 32'hC0DE_0004);

    // Overflow: 15th word without last
    sendWords(15, 1'b0, 0);
    checkEq("ovf_err", err, 1);
    checkEq("ovf_code", err_code, 2);
    pulseErrClr();
    // 15th word carrying last: length check wins
    sendWords(15, 1'b1, 0);
    checkEq("ovf_last_code", err_code, 1);
    pulseErrClr();

    // Done never arrives
    doneEnable = 1'b0;
    sendWords(4, 1'b1, 7);
`ifdef KS_LOADER_TIMEOUT_EN
    repeat (16) begin @(posedge clk); #1; end
    checkEq("to_not_yet", err, 0);
    @(posedge clk); #1;
    checkEq("to_err", err, 1);
    checkEq("to_code", err_code, 3);
    checkEq("to_ks_reset", ks_reset, 1);
    pulseErrClr();
    checkEq("to_clr_ready", s_ready, 1);
`else
    repeat (40) begin @(posedge clk); #1; end
    checkEq("wait_no_err", err, 0);
    checkEq("wait_no_valid", m_valid, 0);
    checkEq("wait_ks_reset", ks_reset, 0);
    reset_n = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
`endif
    doneEnable = 1'b1;

    // Reset asserted while waiting on the core
    sendWords(4, 1'b1, 9);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkEq("abort_ks_reset", ks_reset, 1);
    checkEq("abort_ks_en", ks_en, 0);
    checkEq("abort_ks_k", ks_k, 0);
    checkEq("abort_kwidth", ks_kwidth, 0);
    checkEq("abort_s_ready", s_ready, 0);
    checkEq("abort_m_valid", m_valid, 0);
    #3 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    runKey(4, 11, 2'd0, 32'hC0DE_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
